// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   FIFO_DATA_WIDTH - default word width for both the FIFO and its consumers
//   RD_BUF_DEPTH    - entries in the read-side output buffer
//   occ_t           - occupancy of the read-side buffer (0..RD_BUF_DEPTH)
//   rd_demand()     - words the read side is committed to hold after this edge
package async_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int RD_BUF_DEPTH    = 2;
    localparam int OCC_W           = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // occ + inflight - pop, widened to 3 bits so occ=2, inflight=1 cannot wrap.
    // pop only happens when occ != 0, so the subtraction never underflows.
    function automatic logic [2:0] rd_demand(input occ_t occ, input logic inflight, input logic pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_buf2.sv
// Two-entry circular buffer holding words returned by the async FIFO.
// Latency: write visible on rdata/occ the cycle after wr; rd advances head at the edge.
// Backpressure: none internally; the caller guarantees no write when full.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   wr, wdata - write wdata into the tail entry
//   rd        - retire the head entry
//   rdata     - head entry (zero after reset)
//   occ       - number of valid entries, 0..2
module fifo_rd_buf2
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic                  head_q;
    logic                  tail_q;
    occ_t                  occ_q;
    occ_t                  occ_d;

    // A simultaneous write and read leaves the occupancy unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({wr, rd})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            if (wr) begin
                mem_q[tail_q] <= wdata;
                tail_q        <= ~tail_q;
            end
            if (rd) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async FIFO read port and re-presents the words as a valid/ready stream.
// Latency: fifo_r_en in cycle N -> fifo_data in N+1 -> m_valid in N+2; 1 word/clk sustained.
// Backpressure: m_ready=0 holds m_valid/m_data; pops stop once buffered+in-flight reaches 2.
//
// Ports:
//   rclk, rrst  - read clock, asynchronous active-high reset
//   fifo_empty  - FIFO empty flag (rclk domain)
//   fifo_data   - FIFO registered data_out, valid the cycle after a pop
//   fifo_r_en   - FIFO pop request (combinational from m_ready, intentionally)
//   m_valid, m_ready, m_data - output stream
//   rd_count    - delivered-word counter, present only with FIFO_RD_CNT_EN defined
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    logic       inflight_q;
    logic       inflight_d;
    logic       pop;
    occ_t       buf_occ;
    logic [2:0] demand;

    assign pop    = m_valid & m_ready;
    assign demand = rd_demand(buf_occ, inflight_q, pop);

    // Requesting only while committed words stay below 2 keeps
    // occ + inflight <= 2, so the buffer can never overflow.
    assign fifo_r_en  = !rrst && !fifo_empty && (demand < 3'd2);
    assign inflight_d = fifo_r_en;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // The in-flight word is captured even if the FIFO has gone empty since.
    fifo_rd_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (rclk),
        .rst   (rrst),
        .wr    (inflight_q),
        .wdata (fifo_data),
        .rd    (pop),
        .rdata (m_data),
        .occ   (buf_occ)
    );

    assign m_valid = (buf_occ != '0);

`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] rd_count_q;
    logic [CNT_WIDTH-1:0] rd_count_d;

    // Wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        rd_count_d = rd_count_q;
        if (pop) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-output FIFO model.
// Latency: n/a.
// Backpressure: m_ready driven per scenario.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic          rclk;
    logic          rrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] rd_count;
`endif

    int total;
    int bad;

    // FIFO model: storage written by the stimulus, read pointer owned by the model.
    logic [DW-1:0] fmem [64];
    int            wp;
    int            rp;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign fifo_empty = (rp == wp);

    // Registered data_out, one-cycle read latency; reset drops unread words.
    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rp        <= wp;
            fifo_data <= '0;
        end else if (fifo_r_en && (rp != wp)) begin
            fifo_data <= fmem[rp % 64];
            rp        <= rp + 1;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        fmem[wp % 64] = w;
        wp = wp + 1;
    endtask

    task automatic do_reset();
        rrst    = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst    = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        push(8'hEE);
        #1;
        total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL rst_r_en: got %b want 0", fifo_r_en); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data: got %h want 00", m_data); end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
`endif
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        #1;
        total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL rst_release_r_en: got %b want 0", fifo_r_en); end
        @(posedge rclk);
        #1;
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (fifo_r_en !== (c < 4)) begin bad++; $display("FAIL stream_r_en c%0d: got %b want %b", c, fifo_r_en, (c < 4)); end
            total++;
            if (m_valid !== (c >= 2 && c < 6)) begin bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, m_valid, (c >= 2 && c < 6)); end
            if (c >= 2 && c < 6) begin
                total++;
                if (m_data !== 8'h10 + 8'(c - 2)) begin bad++; $display("FAIL stream_data c%0d: got %h want %h", c, m_data, 8'h10 + 8'(c - 2)); end
            end
            @(posedge rclk);
            #1;
        end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd4) begin bad++; $display("FAIL stream_rd_count: got %0d want 4", rd_count); end
`endif
    endtask

    task automatic test_backpressure();
        int   pops;
        logic stable;
        pops    = 0;
        stable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        for (int c = 0; c < 10; c++) begin
            #1;
            if (fifo_r_en === 1'b1) pops++;
            if (c >= 2 && (m_valid !== 1'b1 || m_data !== 8'h10)) stable = 1'b0;
            @(posedge rclk);
            #1;
        end
        total++; if (pops != 2) begin bad++; $display("FAIL bp_pops: got %0d want 2", pops); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", stable); end
        #1;
        total++; if (m_data !== 8'h10) begin bad++; $display("FAIL bp_head: got %h want 10", m_data); end
        total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL bp_r_en_stopped: got %b want 0", fifo_r_en); end
        @(posedge rclk);
        #1;
        m_ready = 1'b1;
        for (int d = 0; d < 6; d++) begin
            #1;
            total++;
            if (m_valid !== (d < 4)) begin bad++; $display("FAIL bp_drain_valid d%0d: got %b want %b", d, m_valid, (d < 4)); end
            if (d < 4) begin
                total++;
                if (m_data !== 8'h10 + 8'(d)) begin bad++; $display("FAIL bp_drain_data d%0d: got %h want %h", d, m_data, 8'h10 + 8'(d)); end
            end
            @(posedge rclk);
            #1;
        end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd8) begin bad++; $display("FAIL bp_rd_count: got %0d want 8", rd_count); end
`endif
    endtask

    task automatic test_single_word();
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL empty_no_req c%0d: got %b want 0", c, fifo_r_en); end
            @(posedge rclk);
            #1;
        end
        push(8'hA5);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (fifo_r_en !== (c == 0)) begin bad++; $display("FAIL single_r_en c%0d: got %b want %b", c, fifo_r_en, (c == 0)); end
            total++;
            if (m_valid !== (c == 2)) begin bad++; $display("FAIL single_valid c%0d: got %b want %b", c, m_valid, (c == 2)); end
            if (c == 2) begin
                total++;
                if (m_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", m_data); end
            end
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic test_toggle_ready();
        int exp_idx;
        exp_idx = 0;
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 2 == 0);
            #1;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                total++;
                if (m_data !== 8'(exp_idx)) begin bad++; $display("FAIL toggle_data #%0d: got %h want %h", exp_idx, m_data, 8'(exp_idx)); end
                exp_idx++;
            end
            total++;
            if (int'(dut.buf_occ) + int'(dut.inflight_q) > 2) begin
                bad++;
                $display("FAIL toggle_invariant c%0d: got occ+inflight=%0d want <=2", c, int'(dut.buf_occ) + int'(dut.inflight_q));
            end
            @(posedge rclk);
            #1;
        end
        total++; if (exp_idx != 8) begin bad++; $display("FAIL toggle_count: got %0d want 8", exp_idx); end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd1) begin bad++; $display("FAIL toggle_rd_count: got %0d want 1", rd_count); end
`endif
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        repeat (2) begin
            @(posedge rclk);
            #1;
        end
        total++;
        if (dut.buf_occ !== 2'd1 || dut.inflight_q !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_state: got occ=%0d inflight=%b want occ=1 inflight=1", dut.buf_occ, dut.inflight_q);
        end
        rrst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
        total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL mid_rst_r_en: got %b want 0", fifo_r_en); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h want 00", m_data); end
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid: got %b want 0", m_valid); end
        total++; if (fifo_r_en !== 1'b0) begin bad++; $display("FAIL mid_post_r_en: got %b want 0", fifo_r_en); end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL mid_post_rd_count: got %0d want 0", rd_count); end
`endif
        @(posedge rclk);
        #1;
        m_ready = 1'b1;
        push(8'h77);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (m_valid !== (c == 2)) begin bad++; $display("FAIL mid_fresh_valid c%0d: got %b want %b", c, m_valid, (c == 2)); end
            if (c == 2) begin
                total++;
                if (m_data !== 8'h77) begin bad++; $display("FAIL mid_fresh_data: got %h want 77", m_data); end
            end
            @(posedge rclk);
            #1;
        end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd1) begin bad++; $display("FAIL mid_fresh_rd_count: got %0d want 1", rd_count); end
`endif
    endtask

    task automatic test_count_wrap();
        int exp_idx;
        exp_idx = 0;
        do_reset();
        #1;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        for (int c = 0; c < 60; c++) begin
            #1;
            if (m_valid === 1'b1) begin
                total++;
                if (m_data !== 8'h40 + 8'(exp_idx)) begin bad++; $display("FAIL wrap_data #%0d: got %h want %h", exp_idx, m_data, 8'h40 + 8'(exp_idx)); end
                exp_idx++;
            end
            @(posedge rclk);
            #1;
        end
        total++; if (exp_idx != 17) begin bad++; $display("FAIL wrap_delivered: got %0d want 17", exp_idx); end
`ifdef FIFO_RD_CNT_EN
        total++; if (rd_count !== 4'd1) begin bad++; $display("FAIL wrap_rd_count: got %0d want 1", rd_count); end
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        wp      = 0;
        rp      = 0;
        rrst    = 1'b1;
        m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_single_word();
        test_toggle_ready();
        test_reset_mid();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
